// File: rtl/ddio_bidir_turnaround_ctrl_pkg.sv
// rtl/ddio_bidir_turnaround_ctrl_pkg.sv - shared types and limits for the DDIO turnaround controller
package ddio_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    TURN  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  typedef enum logic {
    DIR_WR = 1'b0,
    DIR_RD = 1'b1
  } dir_e;

  localparam int RD_LAT_MAX   = 7;
  localparam int TURN_CYC_MAX = 15;

  // With both requests pending, alternate away from the last burst direction.
  function automatic dir_e pick_dir(input logic wr, input logic rd, input dir_e last);
    if (wr && rd) begin
      if (last == DIR_RD) return DIR_WR;
      else                return DIR_RD;
    end else if (wr) begin
      return DIR_WR;
    end else begin
      return DIR_RD;
    end
  endfunction

endpackage

// File: rtl/ddio_bidir_turnaround_ctrl_if.sv
// rtl/ddio_bidir_turnaround_ctrl_if.sv - requester and DDIO pad-bank signals of the turnaround controller
interface ddio_bidir_turnaround_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              wr_req;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_gnt;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data_h;
  logic [DATA_W-1:0] wr_data_l;
  logic              rd_req;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data_h;
  logic [DATA_W-1:0] rd_data_l;
  logic              busy;
  logic              ddio_oe;
  logic              ddio_outclkena;
  logic              ddio_inclkena;
  logic [DATA_W-1:0] ddio_datain_h;
  logic [DATA_W-1:0] ddio_datain_l;
  logic [DATA_W-1:0] ddio_dataout_h;
  logic [DATA_W-1:0] ddio_dataout_l;

  modport master (
    output wr_req, wr_len, wr_valid, wr_data_h, wr_data_l,
    output rd_req, rd_len, ddio_dataout_h, ddio_dataout_l,
    input  wr_gnt, wr_ready, rd_gnt, rd_valid, rd_data_h, rd_data_l, busy,
    input  ddio_oe, ddio_outclkena, ddio_inclkena, ddio_datain_h, ddio_datain_l
  );

  modport slave (
    input  wr_req, wr_len, wr_valid, wr_data_h, wr_data_l,
    input  rd_req, rd_len, ddio_dataout_h, ddio_dataout_l,
    output wr_gnt, wr_ready, rd_gnt, rd_valid, rd_data_h, rd_data_l, busy,
    output ddio_oe, ddio_outclkena, ddio_inclkena, ddio_datain_h, ddio_datain_l
  );
endinterface

// File: rtl/ddio_bidir_turnaround_ctrl_rd_valid_pipe.sv
// rtl/ddio_bidir_turnaround_ctrl_rd_valid_pipe.sv - read-beat valid shift pipe matching the pad capture latency
module ddio_rd_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push_i,
  output logic valid_o,
  output logic empty_o
);
  logic [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[DEPTH-1];
  assign empty_o = ~|pipe_q;
endmodule

// File: rtl/ddio_bidir_turnaround_ctrl.sv
// rtl/ddio_bidir_turnaround_ctrl.sv - write/read arbiter and bus-turnaround sequencer for a bidir DDIO pad bank
// Optional burst/turnaround statistics counters are built when DDIO_CTRL_STATS_EN is defined.
module ddio_bidir_turnaround_ctrl
  import ddio_ctrl_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 4,
  parameter int TURN_CYC = 2,
  parameter int RD_LAT   = 3
) (
  input  logic clk,
  input  logic reset_n,
`ifdef DDIO_CTRL_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_wr_bursts,
  output logic [15:0] stat_rd_bursts,
  output logic [15:0] stat_turn_cyc,
`endif
  ddio_bidir_turnaround_ctrl_if.slave bus
);

  localparam int TURN_EFF = (TURN_CYC < 1) ? 1 : ((TURN_CYC > TURN_CYC_MAX) ? TURN_CYC_MAX : TURN_CYC);
  localparam int RD_EFF   = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam logic [3:0] TURN_LOAD = 4'(TURN_EFF - 1);

  state_e            state_q;
  dir_e              last_dir_q;
  logic              has_burst_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [3:0]        turn_q;
  logic              wr_gnt_q, rd_gnt_q, wr_ready_q;
  logic              oe_q, outclkena_q, inclkena_q;
  logic [DATA_W-1:0] datain_h_q, datain_l_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_h_q, rd_data_l_q;

  logic req_any, need_turn, turn_done, rd_issue_d, pipe_out, pipe_empty;
  dir_e gnt_dir;

  assign req_any   = bus.wr_req | bus.rd_req;
  assign gnt_dir   = pick_dir(bus.wr_req, bus.rd_req, last_dir_q);
  assign need_turn = has_burst_q && (gnt_dir != last_dir_q);
  assign turn_done = (turn_q == 4'd0);

  // A read beat is issued in every cycle the FSM will spend in READ.
  assign rd_issue_d = ((state_q == IDLE) && req_any && (gnt_dir == DIR_RD) && !need_turn) ||
                      ((state_q == TURN) && turn_done && (last_dir_q == DIR_RD)) ||
                      ((state_q == READ) && (cnt_q != '0));

  ddio_rd_valid_pipe #(.DEPTH(RD_EFF)) u_rd_valid_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (rd_issue_d),
    .valid_o (pipe_out),
    .empty_o (pipe_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_dir_q  <= DIR_RD;
      has_burst_q <= 1'b0;
      cnt_q       <= '0;
      turn_q      <= 4'd0;
      wr_gnt_q    <= 1'b0;
      rd_gnt_q    <= 1'b0;
      wr_ready_q  <= 1'b0;
      oe_q        <= 1'b0;
      outclkena_q <= 1'b0;
      inclkena_q  <= 1'b0;
      datain_h_q  <= '0;
      datain_l_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_h_q <= '0;
      rd_data_l_q <= '0;
    end else begin
      wr_gnt_q    <= 1'b0;
      rd_gnt_q    <= 1'b0;
      outclkena_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_any) begin
            last_dir_q  <= gnt_dir;
            has_burst_q <= 1'b1;
            if (gnt_dir == DIR_WR) begin
              wr_gnt_q <= 1'b1;
              cnt_q    <= bus.wr_len;
            end else begin
              rd_gnt_q <= 1'b1;
              cnt_q    <= bus.rd_len;
            end
            // oe only ever drops here, so the turnaround gap always starts undriven.
            if (need_turn) begin
              state_q <= TURN;
              turn_q  <= TURN_LOAD;
              oe_q    <= 1'b0;
            end else if (gnt_dir == DIR_WR) begin
              state_q    <= WRITE;
              oe_q       <= 1'b1;
              wr_ready_q <= 1'b1;
            end else begin
              state_q    <= READ;
              inclkena_q <= 1'b1;
            end
          end
        end
        TURN: begin
          if (turn_done) begin
            if (last_dir_q == DIR_WR) begin
              state_q    <= WRITE;
              oe_q       <= 1'b1;
              wr_ready_q <= 1'b1;
            end else begin
              state_q    <= READ;
              inclkena_q <= 1'b1;
            end
          end else begin
            turn_q <= turn_q - 4'd1;
          end
        end
        WRITE: begin
          if (bus.wr_valid && wr_ready_q) begin
            datain_h_q  <= bus.wr_data_h;
            datain_l_q  <= bus.wr_data_l;
            outclkena_q <= 1'b1;
            if (cnt_q == '0) begin
              state_q    <= IDLE;
              wr_ready_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end
        end
        READ: begin
          if (cnt_q == '0) begin
            state_q    <= DRAIN;
            inclkena_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (pipe_empty) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      rd_valid_q <= pipe_out;
      if (pipe_out) begin
        rd_data_h_q <= bus.ddio_dataout_h;
        rd_data_l_q <= bus.ddio_dataout_l;
      end
    end
  end

  assign bus.wr_gnt         = wr_gnt_q;
  assign bus.rd_gnt         = rd_gnt_q;
  assign bus.wr_ready       = wr_ready_q;
  assign bus.ddio_oe        = oe_q;
  assign bus.ddio_outclkena = outclkena_q;
  assign bus.ddio_inclkena  = inclkena_q;
  assign bus.ddio_datain_h  = datain_h_q;
  assign bus.ddio_datain_l  = datain_l_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data_h      = rd_data_h_q;
  assign bus.rd_data_l      = rd_data_l_q;
  assign bus.busy           = (state_q != IDLE) || !pipe_empty;

`ifdef DDIO_CTRL_STATS_EN
  logic [15:0] stat_wr_q, stat_rd_q, stat_turn_q;

  always_ff @(posedge clk) begin
    if (!reset_n || stat_clr) begin
      stat_wr_q   <= 16'd0;
      stat_rd_q   <= 16'd0;
      stat_turn_q <= 16'd0;
    end else begin
      if (wr_gnt_q && (stat_wr_q != 16'hFFFF)) stat_wr_q <= stat_wr_q + 16'd1;
      if (rd_gnt_q && (stat_rd_q != 16'hFFFF)) stat_rd_q <= stat_rd_q + 16'd1;
      if ((state_q == TURN) && (stat_turn_q != 16'hFFFF)) stat_turn_q <= stat_turn_q + 16'd1;
    end
  end

  assign stat_wr_bursts = stat_wr_q;
  assign stat_rd_bursts = stat_rd_q;
  assign stat_turn_cyc  = stat_turn_q;
`endif

endmodule

// File: tb/tb_ddio_bidir_turnaround_ctrl.sv
// tb/tb_ddio_bidir_turnaround_ctrl.sv - directed self-checking bench for the DDIO turnaround controller
module tb_ddio_bidir_turnaround_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ddio_bidir_turnaround_ctrl_if #(.DATA_W(8), .LEN_W(4)) ifc ();

  ddio_bidir_turnaround_ctrl #(.DATA_W(8), .LEN_W(4), .TURN_CYC(2), .RD_LAT(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  // Pads carry the cycle number so captured read data identifies its capture cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ifc.ddio_dataout_h = 8'(cyc);
    ifc.ddio_dataout_l = ~8'(cyc);
  endtask

  task automatic clear_inputs();
    ifc.wr_req = 1'b0; ifc.wr_len = 4'd0; ifc.wr_valid = 1'b0;
    ifc.wr_data_h = 8'h00; ifc.wr_data_l = 8'h00;
    ifc.rd_req = 1'b0; ifc.rd_len = 4'd0;
    ifc.ddio_dataout_h = 8'h00; ifc.ddio_dataout_l = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0]  ctl;
    logic [31:0] dat;
    reset_n = 1'b0;
    clear_inputs();
    step(); step();
    ctl = {ifc.wr_gnt, ifc.wr_ready, ifc.rd_gnt, ifc.rd_valid, ifc.busy, ifc.ddio_oe, ifc.ddio_outclkena, ifc.ddio_inclkena};
    dat = {ifc.ddio_datain_h, ifc.ddio_datain_l, ifc.rd_data_h, ifc.rd_data_l};
    n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL reset_ctl got=%b exp=00000000", ctl); end
    n_cmp++; if (dat !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=00000000", dat); end
    reset_n = 1'b1;
    step();
    n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got=%b exp=0", ifc.busy); end
  endtask

  task automatic test_write_burst();
    int n_pulse = 0;
    ifc.wr_req = 1'b1; ifc.wr_len = 4'd3; ifc.wr_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 1) ifc.wr_req = 1'b0;
      if (k <= 4) begin ifc.wr_data_h = 8'(8'h11 * k); ifc.wr_data_l = ~8'(8'h11 * k); end
      n_cmp++; if (ifc.wr_gnt !== (k == 1)) begin n_err++; $display("FAIL wr_gnt k=%0d got=%b exp=%b", k, ifc.wr_gnt, (k == 1)); end
      n_cmp++; if (ifc.ddio_oe !== 1'b1) begin n_err++; $display("FAIL wr_oe k=%0d got=%b exp=1", k, ifc.ddio_oe); end
      n_cmp++; if (ifc.wr_ready !== (k <= 4)) begin n_err++; $display("FAIL wr_ready k=%0d got=%b exp=%b", k, ifc.wr_ready, (k <= 4)); end
      n_cmp++; if (ifc.ddio_outclkena !== (k >= 2 && k <= 5)) begin n_err++; $display("FAIL wr_outclkena k=%0d got=%b exp=%b", k, ifc.ddio_outclkena, (k >= 2 && k <= 5)); end
      if (ifc.ddio_outclkena === 1'b1) n_pulse++;
      if (k >= 2) begin
        n_cmp++;
        if ({ifc.ddio_datain_h, ifc.ddio_datain_l} !== {8'(8'h11 * ((k > 5) ? 4 : k - 1)), ~8'(8'h11 * ((k > 5) ? 4 : k - 1))}) begin
          n_err++; $display("FAIL wr_datain k=%0d got=%h/%h exp=%h", k, ifc.ddio_datain_h, ifc.ddio_datain_l, 8'(8'h11 * ((k > 5) ? 4 : k - 1)));
        end
      end
    end
    ifc.wr_valid = 1'b0;
    n_cmp++; if (n_pulse != 4) begin n_err++; $display("FAIL wr_pulse_count got=%0d exp=4", n_pulse); end
  endtask

  task automatic test_turnaround();
    logic [7:0] exp_d;
    int n_valid = 0;
    ifc.wr_req = 1'b1; ifc.wr_len = 4'd0; ifc.wr_valid = 1'b1; ifc.wr_data_h = 8'h5A; ifc.wr_data_l = 8'hA5;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) begin ifc.wr_req = 1'b0; ifc.rd_req = 1'b1; ifc.rd_len = 4'd1; end
      if (k == 2) ifc.wr_valid = 1'b0;
      if (k == 3) ifc.rd_req = 1'b0;
      if (k == 1) begin n_cmp++; if ({ifc.wr_gnt, ifc.ddio_oe} !== 2'b11) begin n_err++; $display("FAIL ta_wr_gnt_oe got=%b exp=11", {ifc.wr_gnt, ifc.ddio_oe}); end end
      if (k == 2) begin n_cmp++; if ({ifc.ddio_oe, ifc.ddio_outclkena, ifc.ddio_datain_h} !== {2'b11, 8'h5A}) begin n_err++; $display("FAIL ta_wr_beat got=%b%b/%h exp=11/5a", ifc.ddio_oe, ifc.ddio_outclkena, ifc.ddio_datain_h); end end
      if (k == 3) begin n_cmp++; if (ifc.rd_gnt !== 1'b1) begin n_err++; $display("FAIL ta_rd_gnt got=%b exp=1", ifc.rd_gnt); end end
      if (k == 3 || k == 4) begin n_cmp++; if ({ifc.ddio_oe, ifc.ddio_inclkena} !== 2'b00) begin n_err++; $display("FAIL ta_turn k=%0d oe/inclkena got=%b exp=00", k, {ifc.ddio_oe, ifc.ddio_inclkena}); end end
      if (k >= 5 && k <= 7) begin n_cmp++; if ({ifc.ddio_oe, ifc.ddio_inclkena} !== {1'b0, (k != 7)}) begin n_err++; $display("FAIL ta_read k=%0d oe/inclkena got=%b exp=0%b", k, {ifc.ddio_oe, ifc.ddio_inclkena}, (k != 7)); end end
      if (k >= 3) begin
        n_cmp++; if (ifc.rd_valid !== (k == 8 || k == 9)) begin n_err++; $display("FAIL ta_rd_valid k=%0d got=%b exp=%b", k, ifc.rd_valid, (k == 8 || k == 9)); end
      end
      if (ifc.rd_valid === 1'b1) begin
        n_valid++;
        exp_d = 8'(cyc - 1);
        n_cmp++; if ({ifc.rd_data_h, ifc.rd_data_l} !== {exp_d, ~exp_d}) begin n_err++; $display("FAIL ta_rd_data k=%0d got=%h/%h exp=%h/%h", k, ifc.rd_data_h, ifc.rd_data_l, exp_d, ~exp_d); end
      end
      if (k == 9 || k == 10) begin n_cmp++; if (ifc.busy !== (k == 9)) begin n_err++; $display("FAIL ta_busy k=%0d got=%b exp=%b", k, ifc.busy, (k == 9)); end end
    end
    n_cmp++; if (n_valid != 2) begin n_err++; $display("FAIL ta_valid_count got=%0d exp=2", n_valid); end
  endtask

  task automatic test_contention();
    reset_n = 1'b0; step(); reset_n = 1'b1; step();
    ifc.wr_req = 1'b1; ifc.wr_len = 4'd0; ifc.wr_valid = 1'b1; ifc.wr_data_h = 8'h77; ifc.wr_data_l = 8'h88;
    ifc.rd_req = 1'b1; ifc.rd_len = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 1) ifc.wr_req = 1'b0;
      if (k == 2) ifc.wr_valid = 1'b0;
      if (k == 3) ifc.rd_req = 1'b0;
      if (k == 1) begin n_cmp++; if ({ifc.wr_gnt, ifc.rd_gnt, ifc.ddio_oe} !== 3'b101) begin n_err++; $display("FAIL ct_first_grant got=%b exp=101", {ifc.wr_gnt, ifc.rd_gnt, ifc.ddio_oe}); end end
      if (k == 3) begin n_cmp++; if ({ifc.rd_gnt, ifc.ddio_oe} !== 2'b10) begin n_err++; $display("FAIL ct_second_grant got=%b exp=10", {ifc.rd_gnt, ifc.ddio_oe}); end end
      if (k == 5) begin n_cmp++; if (ifc.ddio_inclkena !== 1'b1) begin n_err++; $display("FAIL ct_read_issue got=%b exp=1", ifc.ddio_inclkena); end end
      if (k == 8) begin n_cmp++; if (ifc.rd_valid !== 1'b1) begin n_err++; $display("FAIL ct_rd_valid got=%b exp=1", ifc.rd_valid); end end
      if (k == 9) begin n_cmp++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL ct_done_busy got=%b exp=0", ifc.busy); end end
    end
  endtask

  task automatic test_write_stall();
    int n_pulse = 0;
    logic [7:0] exp_h;
    ifc.wr_req = 1'b1; ifc.wr_len = 4'd2; ifc.wr_valid = 1'b1; ifc.wr_data_h = 8'hAA; ifc.wr_data_l = 8'h55;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) ifc.wr_req = 1'b0;
      ifc.wr_valid = (k <= 3) || (k == 9) || (k == 10);
      if (k == 9)  begin ifc.wr_data_h = 8'hBB; ifc.wr_data_l = 8'h44; end
      if (k == 10) begin ifc.wr_data_h = 8'hCC; ifc.wr_data_l = 8'h33; end
      n_cmp++; if (ifc.ddio_oe !== (k >= 3)) begin n_err++; $display("FAIL st_oe k=%0d got=%b exp=%b", k, ifc.ddio_oe, (k >= 3)); end
      n_cmp++; if (ifc.ddio_outclkena !== (k == 4 || k == 10 || k == 11)) begin n_err++; $display("FAIL st_outclkena k=%0d got=%b exp=%b", k, ifc.ddio_outclkena, (k == 4 || k == 10 || k == 11)); end
      if (ifc.ddio_outclkena === 1'b1) n_pulse++;
      if (k >= 4) begin
        exp_h = (k <= 9) ? 8'hAA : ((k == 10) ? 8'hBB : 8'hCC);
        n_cmp++; if ({ifc.ddio_datain_h, ifc.ddio_datain_l} !== {exp_h, ~exp_h}) begin n_err++; $display("FAIL st_datain k=%0d got=%h/%h exp=%h/%h", k, ifc.ddio_datain_h, ifc.ddio_datain_l, exp_h, ~exp_h); end
      end
      if (k == 10 || k == 11) begin n_cmp++; if (ifc.wr_ready !== (k == 10)) begin n_err++; $display("FAIL st_ready k=%0d got=%b exp=%b", k, ifc.wr_ready, (k == 10)); end end
    end
    n_cmp++; if (n_pulse != 3) begin n_err++; $display("FAIL st_pulse_count got=%0d exp=3", n_pulse); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d;
    int n_valid = 0;
    ifc.rd_req = 1'b1; ifc.rd_len = 4'd1;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 9) ifc.rd_req = 1'b0;
      n_cmp++; if (ifc.rd_gnt !== (k == 1 || k == 9)) begin n_err++; $display("FAIL bb_rd_gnt k=%0d got=%b exp=%b", k, ifc.rd_gnt, (k == 1 || k == 9)); end
      n_cmp++; if (ifc.ddio_inclkena !== (k == 3 || k == 4 || k == 9 || k == 10)) begin n_err++; $display("FAIL bb_inclkena k=%0d got=%b exp=%b", k, ifc.ddio_inclkena, (k == 3 || k == 4 || k == 9 || k == 10)); end
      n_cmp++; if (ifc.rd_valid !== (k == 6 || k == 7 || k == 12 || k == 13)) begin n_err++; $display("FAIL bb_rd_valid k=%0d got=%b exp=%b", k, ifc.rd_valid, (k == 6 || k == 7 || k == 12 || k == 13)); end
      n_cmp++; if (ifc.ddio_oe !== 1'b0) begin n_err++; $display("FAIL bb_oe k=%0d got=%b exp=0", k, ifc.ddio_oe); end
      if (ifc.rd_valid === 1'b1) begin
        n_valid++;
        exp_d = 8'(cyc - 1);
        n_cmp++; if (ifc.rd_data_h !== exp_d) begin n_err++; $display("FAIL bb_rd_data k=%0d got=%h exp=%h", k, ifc.rd_data_h, exp_d); end
      end
      if (k == 13 || k == 14) begin n_cmp++; if (ifc.busy !== (k == 13)) begin n_err++; $display("FAIL bb_busy k=%0d got=%b exp=%b", k, ifc.busy, (k == 13)); end end
    end
    n_cmp++; if (n_valid != 4) begin n_err++; $display("FAIL bb_valid_count got=%0d exp=4", n_valid); end
  endtask

  task automatic test_reset_in_drain();
    logic [7:0]  ctl;
    logic [31:0] dat;
    ifc.rd_req = 1'b1; ifc.rd_len = 4'd3;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k == 1) begin
        ifc.rd_req = 1'b0;
        n_cmp++; if (ifc.rd_gnt !== 1'b1) begin n_err++; $display("FAIL rs_rd_gnt got=%b exp=1", ifc.rd_gnt); end
      end
      if (k == 5) begin
        n_cmp++; if ({ifc.ddio_inclkena, ifc.rd_valid, ifc.busy} !== 3'b011) begin n_err++; $display("FAIL rs_drain got=%b exp=011", {ifc.ddio_inclkena, ifc.rd_valid, ifc.busy}); end
        reset_n = 1'b0;
      end
      if (k == 6) begin
        ctl = {ifc.wr_gnt, ifc.wr_ready, ifc.rd_gnt, ifc.rd_valid, ifc.busy, ifc.ddio_oe, ifc.ddio_outclkena, ifc.ddio_inclkena};
        dat = {ifc.ddio_datain_h, ifc.ddio_datain_l, ifc.rd_data_h, ifc.rd_data_l};
        n_cmp++; if (ctl !== 8'h00) begin n_err++; $display("FAIL rs_ctl got=%b exp=00000000", ctl); end
        n_cmp++; if (dat !== 32'h0) begin n_err++; $display("FAIL rs_data got=%h exp=00000000", dat); end
        reset_n = 1'b1;
      end
      if (k >= 7 && k <= 9) begin n_cmp++; if (ifc.rd_valid !== 1'b0) begin n_err++; $display("FAIL rs_no_valid k=%0d got=%b exp=0", k, ifc.rd_valid); end end
      if (k == 9) begin ifc.wr_req = 1'b1; ifc.wr_len = 4'd0; ifc.wr_valid = 1'b1; ifc.wr_data_h = 8'h3C; ifc.wr_data_l = 8'hC3; end
      if (k == 10) begin
        n_cmp++; if ({ifc.wr_gnt, ifc.ddio_oe, ifc.wr_ready} !== 3'b111) begin n_err++; $display("FAIL rs_wr_no_turn got=%b exp=111", {ifc.wr_gnt, ifc.ddio_oe, ifc.wr_ready}); end
        ifc.wr_req = 1'b0;
      end
      if (k == 11) begin
        n_cmp++; if ({ifc.ddio_outclkena, ifc.ddio_datain_h} !== {1'b1, 8'h3C}) begin n_err++; $display("FAIL rs_wr_beat got=%b/%h exp=1/3c", ifc.ddio_outclkena, ifc.ddio_datain_h); end
        ifc.wr_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_turnaround();
    test_contention();
    test_write_stall();
    test_back_to_back();
    test_reset_in_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ddio_bidir_turnaround_ctrl.md
Name: ddio_bidir_turnaround_ctrl

Overview:
Sequences a shared DDIO bidirectional pad bank built from the team's bidir DDIO cells with no async reset. Arbitrates between a write requester and a read requester. Drives oe, output data and clock enables, inserts programmable bus-turnaround gaps, and returns captured high/low read data with a valid strobe. Sits between the memory-interface command logic and the per-pin DDIO atoms.

Parameters:
DATA_W, 8, bits per DDIO edge (width of each h/l data bus)
LEN_W, 4, burst length field width; burst beats = len+1
TURN_CYC, 2, idle cycles forced on every write<->read direction change (1..15)
RD_LAT, 3, cycles from oe=0 beat issue to valid dataout_h/l at the controller (1..7)

Ports:
clk  input  1  single clock for controller and both DDIO clock domains
reset_n  input  1  synchronous active-low reset
wr_req  input  1  write burst request; held until wr_gnt
wr_len  input  LEN_W  write beats-1; sampled at grant
wr_gnt  output  1  one-cycle grant pulse for write
wr_valid  input  1  write beat data valid
wr_ready  output  1  controller accepts a write beat
wr_data_h  input  DATA_W  rising-edge beat data
wr_data_l  input  DATA_W  falling-edge beat data
rd_req  input  1  read burst request; held until rd_gnt
rd_len  input  LEN_W  read beats-1; sampled at grant
rd_gnt  output  1  one-cycle grant pulse for read
rd_valid  output  1  captured read beat valid
rd_data_h  output  DATA_W  captured rising-edge data
rd_data_l  output  DATA_W  captured falling-edge data
busy  output  1  state != IDLE or read pipeline non-empty
ddio_oe  output  1  output enable to DDIO cells
ddio_outclkena  output  1  output register clock enable
ddio_inclkena  output  1  input register clock enable
ddio_datain_h  output  DATA_W  to DDIO datain_h
ddio_datain_l  output  DATA_W  to DDIO datain_l
ddio_dataout_h  input  DATA_W  from DDIO dataout_h
ddio_dataout_l  input  DATA_W  from DDIO dataout_l

Behaviour:
- Reset (sync, reset_n=0 at clk edge): state IDLE; every output 0; beat counter 0; turnaround counter 0; read-valid shift pipe cleared; last_dir=READ, so the first contention grants write.
- States: IDLE, WRITE, READ, TURN, DRAIN.
- IDLE: if exactly one req is high, grant it. If both are high, grant the direction opposite last_dir.
  - Grant pulses wr_gnt/rd_gnt for one cycle, latches len into the beat counter, and sets last_dir.
  - If the granted direction differs from the previous burst direction, go to TURN for TURN_CYC cycles, then to the burst state. Otherwise go to the burst state directly.
  - The first burst after reset needs no turnaround.
- WRITE: ddio_oe=1 for the whole state. wr_ready=1.
  - On a beat (wr_valid&wr_ready): register wr_data_h/l onto ddio_datain_h/l, pulse ddio_outclkena=1, decrement the counter.
  - With wr_valid=0: outclkena=0, data held, oe stays 1 (stall, no timeout).
  - The last beat goes to IDLE with wr_ready=0 in the next cycle.
- READ: ddio_oe=0. Issues one beat per cycle with no stall: inclkena=1, and a 1 is pushed into an RD_LAT-deep valid shift pipe.
  - After len+1 beats go to DRAIN.
- DRAIN: oe=0; wait until the valid pipe is empty, then go to IDLE.
- Read capture: when the pipe output is 1, register ddio_dataout_h/l to rd_data_h/l and assert rd_valid for that cycle.
  - First rd_valid appears RD_LAT cycles after the first READ cycle.
  - Exactly len+1 rd_valid pulses per burst.
  - rd_data holds its value when rd_valid=0.
- oe transitions happen only in TURN. oe is never 1 while the read pipe is non-empty.
- Back-to-back same-direction bursts: IDLE costs one cycle between bursts; no TURN.
- A request dropped before grant is ignored. Requests are not sampled outside IDLE.
- Reset mid-burst: immediate return to reset values; any partial read data is discarded.

Optional Feature:
DDIO_CTRL_STATS_EN. When defined, adds outputs stat_wr_bursts[15:0], stat_rd_bursts[15:0] and stat_turn_cyc[15:0] (saturating counters; cleared by reset), plus input stat_clr (synchronous clear). When undefined, these ports and all counter logic are absent.

Decomposition:
- Package ddio_ctrl_pkg: state enum (IDLE, WRITE, READ, TURN, DRAIN), direction enum (DIR_WR, DIR_RD), and the constants for RD_LAT max=7 and TURN_CYC max=15.
- One sub-module, ddio_rd_valid_pipe: RD_LAT-deep shift register with an empty flag.

Test Plan:
- Reset, then wr_req with wr_len=3 and wr_valid held high: wr_gnt in cycle 1; 4 outclkena pulses carrying data 0x11..0x44; oe=1 throughout; no TURN.
- Write len=0 followed by rd_req len=1 (TURN_CYC=2, RD_LAT=3): exactly 2 cycles with oe=0 and inclkena=0 before READ; 2 rd_valid pulses, the first 3 cycles after READ entry, with data equal to the driven pad values.
- wr_req and rd_req asserted simultaneously after reset: write granted first; read granted at the next IDLE.
- Write burst len=2 with wr_valid low for 5 cycles mid-burst: oe stays 1, outclkena=0 during the stall, 3 beats total, correct order.
- Two back-to-back reads of len=1: 1 IDLE cycle between them, no TURN; 4 rd_valid pulses total; busy drops only after the last one.
- Apply reset_n=0 during DRAIN: next cycle all outputs are 0, no further rd_valid; a subsequent write is granted without TURN.
